// File: rtl/monitor_pkg.sv
// -----------------------------------------------------------------------------
// monitor_pkg
//   Types and constants shared by the monitor event arbiter and the
//   active-device monitor it feeds.
//   - mon_state_e     : arbiter FSM states
//   - MON_CNT_W       : default active-device count width
//   - MON_MAX_DEV     : default highest legal active-device count
//   - MON_REJ_CNT_W   : width of the optional rejection statistics counter
// -----------------------------------------------------------------------------
package monitor_pkg;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_ISSUE   = 2'd1,
    MON_RECOVER = 2'd2
  } mon_state_e;

  localparam int MON_CNT_W     = 8;
  localparam int MON_MAX_DEV   = 255;
  localparam int MON_REJ_CNT_W = 16;

endpackage : monitor_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotating-priority search. The search begins at
//   last_grant+1 (mod N_REQ) and returns the first requester found.
//   Ports:
//     req        in  N_REQ          : request vector
//     last_grant in  $clog2(N_REQ)  : index granted most recently
//     win_idx    out $clog2(N_REQ)  : winning index (0 when valid is low)
//     valid      out 1              : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] win_idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    win_idx = '0;
    valid   = 1'b0;
    cand    = '0;
    // k runs 1..N_REQ so the previous winner is examined last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!valid && req[cand]) begin
        win_idx = cand;
        valid   = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/monitor_event_arbiter.sv
// -----------------------------------------------------------------------------
// monitor_event_arbiter
//   Serialises connect/disconnect events from N_REQ gateways into the single
//   change/on_off command pair of the active-device monitor. Requesters are
//   served round-robin; a shadow count of active devices is kept so that any
//   event that would overflow (above MAX_DEV) or underflow (below 0) the
//   monitor is refused instead of issued. Each event takes three cycles:
//   IDLE (sample + decide), ISSUE (outputs pulse), RECOVER (requester drops).
//
//   Optional feature: define MONITOR_ARB_STATS_EN to add the rej_count output.
//
//   Ports:
//     clk          in  1      : clock, rising edge
//     rst          in  1      : synchronous active-high reset
//     req          in  N_REQ  : level event request, held until ack/rej
//     req_on_off   in  N_REQ  : direction, 1 = connect, 0 = disconnect
//     ack          out N_REQ  : one-hot 1-cycle pulse, event issued
//     rej          out N_REQ  : one-hot 1-cycle pulse, event refused
//     change       out 1      : monitor strobe, 1 cycle per issued event
//     on_off       out 1      : monitor direction, 0 whenever change is 0
//     active_count out CNT_W  : shadow active-device count
//     busy         out 1      : FSM is not in IDLE
//     rej_count    out 16     : saturating rejection count (stats build only)
// -----------------------------------------------------------------------------
module monitor_event_arbiter
  import monitor_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = MON_CNT_W,
  parameter int MAX_DEV = MON_MAX_DEV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_on_off,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         rej,
  output logic                     change,
  output logic                     on_off,
  output logic [CNT_W-1:0]         active_count,
  output logic                     busy
`ifdef MONITOR_ARB_STATS_EN
  ,
  output logic [MON_REJ_CNT_W-1:0] rej_count
`endif
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] MAX_DEV_C = CNT_W'(MAX_DEV);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  mon_state_e       state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] rej_q, rej_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             win_dir;
  logic             accept;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant_q),
    .win_idx    (arb_idx),
    .valid      (arb_valid)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic. The accept/reject decision is made while
  // still in IDLE so that ack/rej/change can come straight from flops during
  // ISSUE; the count itself moves at the end of ISSUE, in step with the
  // monitor consuming change.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    ack_d        = '0;
    rej_d        = '0;
    change_d     = 1'b0;
    on_off_d     = 1'b0;
    win_dir      = req_on_off[arb_idx];
    accept       = win_dir ? (count_q < MAX_DEV_C) : (count_q != '0);

    unique case (state_q)
      MON_IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          state_d = MON_ISSUE;
          if (accept) begin
            ack_d[arb_idx] = 1'b1;
            change_d       = 1'b1;
            on_off_d       = win_dir;
          end else begin
            rej_d[arb_idx] = 1'b1;
          end
        end
      end

      MON_ISSUE: begin
        last_grant_d = win_q;
        if (change_q) begin
          count_d = on_off_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        end
        state_d = MON_RECOVER;
      end

      MON_RECOVER: begin
        // Requests are ignored here so the served requester can drop req.
        state_d = MON_IDLE;
      end

      default: begin
        state_d = MON_IDLE;
      end
    endcase

    busy_d = (state_d != MON_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    if (rst) begin
      // NOTE: only control and counter flops live here, so each one gets an
      // explicit reset value; a dropped ISSUE event never reaches the count.
      state_q      <= MON_IDLE;
      win_q        <= '0;
      last_grant_q <= LAST_IDX;
      ack_q        <= '0;
      rej_q        <= '0;
      change_q     <= 1'b0;
      on_off_q     <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      rej_q        <= rej_d;
      change_q     <= change_d;
      on_off_q     <= on_off_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
    end
  end

  assign ack          = ack_q;
  assign rej          = rej_q;
  assign change       = change_q;
  assign on_off       = on_off_q;
  assign active_count = count_q;
  assign busy         = busy_q;

`ifdef MONITOR_ARB_STATS_EN
  // Saturating count of refused events, advanced on each rej pulse.
  logic [MON_REJ_CNT_W-1:0] rej_count_q, rej_count_d;

  always_comb begin
    rej_count_d = rej_count_q;
    if ((|rej_q) && (rej_count_q != '1)) begin
      rej_count_d = rej_count_q + MON_REJ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rej_count_q <= '0;
    end else begin
      rej_count_q <= rej_count_d;
    end
  end

  assign rej_count = rej_count_q;
`endif

endmodule : monitor_event_arbiter

// File: tb/tb_monitor_event_arbiter.sv
module tb_monitor_event_arbiter;

  localparam int N_REQ   = 4;
  localparam int CNT_W   = 8;
  localparam int MAX_DEV = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] req_on_off = '0;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] rej;
  logic             change;
  logic             on_off;
  logic [CNT_W-1:0] active_count;
  logic             busy;
`ifdef MONITOR_ARB_STATS_EN
  logic [15:0]      rej_count;
`endif

  always #5 clk = ~clk;

  monitor_event_arbiter #(
    .N_REQ   (N_REQ),
    .CNT_W   (CNT_W),
    .MAX_DEV (MAX_DEV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_on_off   (req_on_off),
    .ack          (ack),
    .rej          (rej),
    .change       (change),
    .on_off       (on_off),
    .active_count (active_count),
    .busy         (busy)
`ifdef MONITOR_ARB_STATS_EN
    ,
    .rej_count    (rej_count)
`endif
  );

  typedef struct {
    int               cyc;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] rej;
    logic             change;
    logic             on_off;
    int               count_after;
    int               rejc;
  } exp_t;

  exp_t             q[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               grant_cnt = 0;
  int               m_count = 0;
  int               m_last = N_REQ - 1;
  int               m_rejc = 0;
  logic [N_REQ-1:0] hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides, just before each rising edge, whether the
  // arbiter is free to sample and what the served event must produce.
  // An event occupies the arbiter for three edges (sample, issue, recover).
  initial begin : model
    int   skip;
    int   w;
    int   p;
    logic dir;
    logic ok;
    exp_t e;
    skip = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_count = 0;
        m_last  = N_REQ - 1;
        m_rejc  = 0;
        skip    = 0;
      end else if (skip > 0) begin
        skip--;
      end else if (|req) begin
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          p = (m_last + k) % N_REQ;
          if (w < 0 && req[p]) w = p;
        end
        dir      = req_on_off[w];
        ok       = dir ? (m_count < MAX_DEV) : (m_count > 0);
        e.cyc    = cyc + 1;
        e.ack    = '0;
        e.rej    = '0;
        e.change = ok;
        e.on_off = ok ? dir : 1'b0;
        if (ok) begin
          e.ack[w] = 1'b1;
          m_count  = dir ? m_count + 1 : m_count - 1;
        end else begin
          e.rej[w] = 1'b1;
          m_rejc++;
        end
        e.count_after = m_count;
        e.rejc        = m_rejc;
        q.push_back(e);
        m_last = w;
        skip   = 2;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard after every edge.
  initial begin : monitor
    bit   pend;
    exp_t pe;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        check("active_count", 32'(active_count), rst ? 32'd0 : 32'(pe.count_after));
`ifdef MONITOR_ARB_STATS_EN
        check("rej_count", 32'(rej_count), rst ? 32'd0 : 32'(pe.rejc));
`endif
        pend = 1'b0;
      end
      if (rst) begin
        check("reset_outputs", 32'({ack, rej, change, on_off, active_count, busy}), 32'd0);
      end else if ((|ack) || (|rej) || change) begin
        grant_cnt++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: ack=%b rej=%b with no event expected (cycle %0d)",
                   ack, rej, cyc);
        end else begin
          e = q.pop_front();
          check("grant_cycle", 32'(cyc), 32'(e.cyc));
          check("ack", 32'(ack), 32'(e.ack));
          check("rej", 32'(rej), 32'(e.rej));
          check("change_on_off", 32'({change, on_off}), 32'({e.change, e.on_off}));
          check("busy_in_issue", 32'(busy), 32'd1);
          pe   = e;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      if ((ack[i] || rej[i]) && !hold[i]) req[i] = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int target;
    int c;
    target = grant_cnt + n;
    c      = 0;
    while (grant_cnt < target && c < budget) begin
      tick();
      c++;
    end
    if (grant_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL wait_grants: saw %0d of %0d grants within %0d cycles",
               n - (target - grant_cnt), n, budget);
    end
  endtask

  task automatic do_reset();
    tick();
    rst  = 1'b1;
    req  = '0;
    hold = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Single connect event from port 0.
    do_reset();
    req_on_off = 4'b0001;
    req        = 4'b0001;
    wait_grants(1, 20);
    @(posedge clk);
    #1;
    check("busy_recover", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("count_one", 32'(active_count), 32'd1);

    // All ports held high, direction up: strict rotation 0,1,2,3,0.
    do_reset();
    req_on_off = 4'b1111;
    hold       = 4'b1111;
    req        = 4'b1111;
    wait_grants(5, 40);
    hold = '0;
    req  = '0;
    tick();
    tick();
    check("count_five", 32'(active_count), 32'd5);

    // Disconnect at count 0 is refused.
    do_reset();
    req_on_off = 4'b0000;
    req        = 4'b0100;
    wait_grants(1, 20);

    // Fill to MAX_DEV, then one refused connect and one accepted disconnect.
    req_on_off = 4'b0001;
    hold       = 4'b0001;
    req        = 4'b0001;
    wait_grants(MAX_DEV, 1000);
    wait_grants(1, 20);
    hold   = '0;
    req[0] = 1'b0;
    tick();
    check("count_full", 32'(active_count), 32'(MAX_DEV));
    req_on_off[1] = 1'b0;
    req[1]        = 1'b1;
    wait_grants(1, 20);
    tick();
    check("count_after_down", 32'(active_count), 32'(MAX_DEV - 1));

    // Reset while ISSUE is on the outputs, then the next grant starts at 0.
    req_on_off[3] = 1'b1;
    req           = 4'b1000;
    wait_grants(1, 20);
    rst = 1'b1;
    req = '0;
    tick();
    rst        = 1'b0;
    req_on_off = 4'b0101;
    req        = 4'b0101;
    wait_grants(2, 30);

    // Port 1 keeps req high through RECOVER: served twice.
    req_on_off = 4'b0010;
    hold       = 4'b0010;
    req        = 4'b0010;
    wait_grants(2, 30);
    hold = '0;
    req  = '0;
    tick();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        req = '0;
      end else begin
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            req_on_off[i] = ($urandom_range(0, 9) < 6);
            req[i]        = 1'b1;
          end
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (10) tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_monitor_event_arbiter
